instr_mem_ctrl: RTL
===================

Name: instr_mem_ctrl

Overview:
Parametrised instruction memory with a registered fetch port, a stall/hold handshake, a run-time program-load port and a post-reset fill sequencer. It sits between the PC/fetch stage and the decoder. It replaces the fixed 256 x 32 ROM-style store with configurable depth and width. Code images are loaded by a host or bootloader instead of being hard-coded.

Parameters:
DATA_W, 32, instruction word width in bits.
ADDR_W, 8, width of the fetch and load address.
DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_W.
FILL_WORD, 32'h5400_0000, NOP encoding (opcode 010101) written by the fill sequencer and returned on an out-of-range fetch.
CLEAR_ON_RESET, 1, 1 = run the fill sequence after reset; 0 = go straight to READY.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_req  in  1  fetch request for fetch_addr.
fetch_addr  in  ADDR_W  word address supplied by the PC.
fetch_stall  in  1  downstream stall; holds the output word.
instr  out  DATA_W  registered instruction word.
instr_valid  out  1  instr holds the result of an accepted fetch.
addr_err  out  1  the accepted fetch was out of range (fetch_addr >= DEPTH).
ld_we  in  1  program-load write strobe.
ld_addr  in  ADDR_W  program-load word address.
ld_data  in  DATA_W  program-load data.
ld_ack  out  1  one-cycle pulse acknowledging a load write.
ready  out  1  block is in READY and accepts fetches and loads.

Behaviour:
- Reset (rst_n low, asynchronous):
  - instr = 0, instr_valid = 0, addr_err = 0, ld_ack = 0, ready = 0.
  - Fill counter = 0.
  - FSM goes to CLEAR if CLEAR_ON_RESET = 1, otherwise to READY.
  - Memory contents are not reset.
- FSM state CLEAR:
  - Each edge writes FILL_WORD to mem[cnt] and increments cnt.
  - On the edge that writes mem[DEPTH-1], the FSM moves to READY and ready is set on that same edge.
  - Result: ready is 1 after exactly DEPTH edges following reset release.
  - fetch_req is ignored and instr_valid stays 0.
  - ld_we is ignored and no ld_ack is generated.
- FSM state READY (ready = 1). READY is terminal until the next reset.
- With CLEAR_ON_RESET = 0, ready is 1 after the first edge following reset release.
- Fetch timing (1-cycle latency), evaluated at each edge in READY:
  - fetch_stall = 1: instr, instr_valid and addr_err hold. fetch_req and fetch_addr are ignored. Stall has priority over req.
  - fetch_req = 1, fetch_stall = 0: instr <= mem[fetch_addr], instr_valid <= 1, addr_err <= 0.
  - Same case with fetch_addr >= DEPTH: instr <= FILL_WORD, addr_err <= 1, instr_valid <= 1. Memory is not accessed.
  - fetch_req = 0, fetch_stall = 0: instr_valid <= 0, addr_err <= 0, instr holds its last value.
  - Back-to-back fetches on consecutive cycles are fully supported; throughput is one word per cycle.
- Load, with ld_we = 1 in READY:
  - mem[ld_addr] <= ld_data at the edge.
  - ld_ack = 1 for the following cycle only.
  - Consecutive ld_we cycles give consecutive ack pulses.
  - If ld_addr >= DEPTH, the write is suppressed but ld_ack still pulses, so the host never hangs.
- Simultaneous fetch and load to the same address in the same cycle: read-before-write. instr returns the old word; the next fetch returns the new word.
- Simultaneous fetch and load to different addresses: both complete in the same cycle with no stall.
- Reset asserted mid-CLEAR or mid-operation: immediate return to the reset values, and the fill restarts from address 0. Words already written keep their values.
- Widths:
  - Address comparisons are unsigned on the full ADDR_W.
  - When DEPTH = 2**ADDR_W, addr_err can never assert.
  - The fill counter is ADDR_W+1 bits wide, so DEPTH = 2**ADDR_W terminates correctly.
- Memory is a single inferred synchronous RAM with one read port and one write port. The write port is shared by the fill sequencer and the load port; the two never overlap because they are separated by FSM state.

Test Plan:
1. DEFAULTS; release rst_n and count edges until ready -> ready rises after exactly 256 edges; then fetch addr 0, 37 and 255 -> each returns 32'h5400_0000 with instr_valid = 1 one cycle after the request.
2. Load mem[5] = 32'h0800_0008 -> ld_ack pulses for 1 cycle. Fetch addr 5 -> instr = 32'h0800_0008 next cycle. Back-to-back fetches of 5,6,5 -> outputs 08000008, 54000000, 08000008 on consecutive cycles.
3. Fetch addr 5, then assert fetch_stall for 3 cycles while changing fetch_addr to 9 with fetch_req = 1 -> instr stays 32'h0800_0008 with instr_valid = 1. After the stall drops, addr 9 is returned next cycle.
4. DEPTH = 200: fetch addr 220 -> instr = 32'h5400_0000, addr_err = 1, instr_valid = 1. Load to addr 220 -> ld_ack pulses, and no word in 0..199 changes.
5. Same cycle: fetch addr 12 and load mem[12] = 32'h1800_0000 -> instr = old word 32'h5400_0000. Next fetch of 12 -> 32'h1800_0000.
6. Assert rst_n low at edge 100 of CLEAR for 2 cycles, then release -> all outputs return to 0 at once, ready rises 256 edges after release, and no ld_ack is produced by ld_we driven during CLEAR. With CLEAR_ON_RESET = 0 -> ready = 1 after 1 edge.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - parametrised instruction memory with registered fetch, stall hold, load port and post-reset fill
module instr_mem_ctrl #(
  parameter int                DATA_W         = 32,
  parameter int                ADDR_W         = 8,
  parameter int                DEPTH          = 256,
  parameter logic [DATA_W-1:0] FILL_WORD      = 32'h5400_0000,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_err,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic              ready
);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  // One extra counter bit so DEPTH == 2**ADDR_W still reaches its last index cleanly.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  state_t            state, state_next;
  logic [ADDR_W:0]   cnt, cnt_next;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              fetch_in_range;
  logic              ld_in_range;

  assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_C);
  assign ld_in_range    = ({1'b0, ld_addr} < DEPTH_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= (state_next == ST_READY);
    end
  end

  // Fill sequencer and load port share the single write port; FSM state keeps them apart.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_we     = 1'b0;
    mem_waddr  = ld_addr;
    mem_wdata  = ld_data;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt[ADDR_W-1:0];
        mem_wdata = FILL_WORD;
        cnt_next  = cnt + 1'b1;
        if (cnt == LAST_C) state_next = ST_READY;
      end
      ST_READY: begin
        mem_we = ld_we && ld_in_range;
      end
      default: state_next = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Reads sample the pre-write contents, giving read-before-write on address collisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      addr_err    <= 1'b0;
      ld_ack      <= 1'b0;
    end else begin
      ld_ack <= (state == ST_READY) && ld_we;
      if (state == ST_READY && !fetch_stall) begin
        if (fetch_req) begin
          instr_valid <= 1'b1;
          if (fetch_in_range) begin
            instr    <= mem[fetch_addr];
            addr_err <= 1'b0;
          end else begin
            instr    <= FILL_WORD;
            addr_err <= 1'b1;
          end
        end else begin
          instr_valid <= 1'b0;
          addr_err    <= 1'b0;
        end
      end
    end
  end

endmodule
